// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sequencer: state encoding and
// reference truth tables for two-input gates.
package tts_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETTLE_ENC = 2'd1;
  localparam logic [1:0] ST_SAMPLE_ENC = 2'd2;
  localparam logic [1:0] ST_FINISH_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_SAMPLE = ST_SAMPLE_ENC,
    ST_FINISH = ST_FINISH_ENC
  } state_t;

  // Bit i is the gate output for input vector i (bit0 = a, bit1 = b).
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  function automatic int tt_width(input int n_inputs);
    return 1 << n_inputs;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control/result bundle between a truth-table sequencer (slave) and the
// bench or self-test controller driving it (master).
interface truth_table_sequencer_if #(
  parameter int N_INPUTS = 2
);
  localparam int TT_W = 1 << N_INPUTS;

  logic                start;
  logic                abort;
  logic                dut_y;
  logic [N_INPUTS-1:0] vec_out;
  logic                busy;
  logic                done;
  logic                result_valid;
  logic                pass;
  logic [N_INPUTS:0]   err_count;
  logic [N_INPUTS-1:0] first_fail;
  logic [TT_W-1:0]     captured;

  modport master (
    output start, abort, dut_y,
    input  vec_out, busy, done, result_valid, pass, err_count, first_fail, captured
  );

  modport slave (
    input  start, abort, dut_y,
    output vec_out, busy, done, result_valid, pass, err_count, first_fail, captured
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; zero_o flags that the current vector has been held
// long enough to be sampled.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input vector onto a combinational gate, samples its output after
// a settle time and scores the captured truth table against EXPECTED.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int                         N_INPUTS      = 2,
  parameter logic [(1<<N_INPUTS)-1:0]   EXPECTED      = TT_AND,
  parameter int                         SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  truth_table_sequencer_if.slave   bus
);

  localparam int                  TT_W    = tt_width(N_INPUTS);
  localparam int                  CNT_W   = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]    RELOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_MAX = '1;

  state_t              state_q;
  logic [N_INPUTS-1:0] vec_q;
  logic [N_INPUTS-1:0] first_fail_q;
  logic [N_INPUTS:0]   err_q;
  logic [N_INPUTS:0]   err_d;
  logic [TT_W-1:0]     cap_q;
  logic                busy_q;
  logic                done_q;
  logic                rv_q;
  logic                pass_q;
  logic                mismatch;
  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;

  assign mismatch = (bus.dut_y != EXPECTED[vec_q]);
  assign err_d    = err_q + {{N_INPUTS{1'b0}}, mismatch};

  // Reload on every SAMPLE; harmless on the last vector since IDLE reloads on start.
  assign tmr_load = ((state_q == ST_IDLE) && bus.start) || (state_q == ST_SAMPLE);
  assign tmr_dec  = (state_q == ST_SETTLE) && !tmr_zero;

  settle_timer #(
    .W (CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      first_fail_q <= '0;
      err_q        <= '0;
      cap_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rv_q         <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          vec_q <= '0;
          if (bus.start) begin
            rv_q         <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
            cap_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
          end else if (tmr_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
          end else begin
            cap_q[vec_q] <= bus.dut_y;
            err_q        <= err_d;
            if (mismatch && (err_q == '0)) begin
              first_fail_q <= vec_q;
            end
            // Results are published together with done so pass already sees the last vector.
            if (vec_q == VEC_MAX) begin
              state_q <= ST_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              rv_q    <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q   <= vec_q + 1'b1;
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_FINISH: begin
          vec_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec_out      = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = rv_q;
  assign bus.pass         = pass_q;
  assign bus.err_count    = err_q;
  assign bus.first_fail   = first_fail_q;
  assign bus.captured     = cap_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: expected tables are queued at start and compared when done pulses.
module tb_truth_table_sequencer;
  import tts_pkg::*;

  localparam int N  = 2;
  localparam int TW = 4;

  typedef struct packed {
    logic [TW-1:0] cap;
    logic [N:0]    err;
    logic [N-1:0]  ff;
    logic          pass;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sequencer_if #(.N_INPUTS(N)) bus0 ();
  truth_table_sequencer_if #(.N_INPUTS(N)) bus1 ();

  truth_table_sequencer #(.N_INPUTS(N), .EXPECTED(TT_AND), .SETTLE_CYCLES(1)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  truth_table_sequencer #(.N_INPUTS(N), .EXPECTED(TT_AND), .SETTLE_CYCLES(3)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int   gate_sel = 0;
  int   sel      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  res_t q[$];

  // 0 AND, 1 XOR, 2 OR, 3 NAND
  function automatic logic gate_f(input int g, input logic [N-1:0] v);
    case (g)
      1:       return v[0] ^ v[1];
      2:       return v[0] | v[1];
      3:       return ~(v[0] & v[1]);
      default: return v[0] & v[1];
    endcase
  endfunction

  assign bus0.dut_y = gate_f(gate_sel, bus0.vec_out);
  assign bus1.dut_y = bus1.vec_out[0] & bus1.vec_out[1];

  logic          m_done, m_busy, m_rv;
  logic [N-1:0]  m_vec;
  res_t          act;
  always_comb begin
    if (sel == 1) begin
      m_done = bus1.done; m_busy = bus1.busy; m_rv = bus1.result_valid; m_vec = bus1.vec_out;
      act    = {bus1.captured, bus1.err_count, bus1.first_fail, bus1.pass};
    end else begin
      m_done = bus0.done; m_busy = bus0.busy; m_rv = bus0.result_valid; m_vec = bus0.vec_out;
      act    = {bus0.captured, bus0.err_count, bus0.first_fail, bus0.pass};
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_assert++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic res_t model(input int g, input logic [TW-1:0] exp_tt);
    res_t r;
    bit   seen;
    r    = '0;
    seen = 1'b0;
    for (int v = 0; v < TW; v++) begin
      logic [N-1:0] vv;
      logic         y;
      vv       = v[N-1:0];
      y        = gate_f(g, vv);
      r.cap[v] = y;
      if (y != exp_tt[v]) begin
        if (!seen) r.ff = vv;
        seen  = 1'b1;
        r.err = r.err + 1'b1;
      end
    end
    r.pass = (r.err == '0);
    return r;
  endfunction

  // Called at posedge+1; leaves the bench at E0+1 with start already accepted.
  task automatic start_run(input int s, input int g, input bit with_abort);
    sel      = s;
    if (s == 0) gate_sel = g;
    q.push_back(model((s == 0) ? g : 0, TT_AND));
    if (s == 0) begin bus0.start = 1'b1; bus0.abort = with_abort; end
    else        begin bus1.start = 1'b1; bus1.abort = with_abort; end
    @(posedge clk); #1;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    check("start_clears_rv", m_rv, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int c0, input int s, input int lat);
    int   cyc;
    res_t e;
    cyc = c0;
    while (m_done !== 1'b1 && cyc < lat + 20) begin
      check({tag, "_vec"}, m_vec, cyc / (s + 1));
      check({tag, "_busy"}, m_busy, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_done"}, m_done, 1'b1);
    check({tag, "_rv"}, m_rv, 1'b1);
    check({tag, "_busy_fin"}, m_busy, 1'b0);
    check({tag, "_vec_fin"}, m_vec, TW - 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, "_captured"}, act.cap, e.cap);
      check({tag, "_err_count"}, act.err, e.err);
      check({tag, "_first_fail"}, act.ff, e.ff);
      check({tag, "_pass"}, act.pass, e.pass);
    end else begin
      check({tag, "_queue_empty"}, 1, 0);
    end
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, m_done, 1'b0);
    check({tag, "_rv_hold"}, m_rv, 1'b1);
    check({tag, "_vec_idle"}, m_vec, 0);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (m_done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    #12;
    check("rst_vec", bus0.vec_out, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);
    check("rst_rv", bus0.result_valid, 0);
    check("rst_pass", bus0.pass, 0);
    check("rst_err", bus0.err_count, 0);
    check("rst_ff", bus0.first_fail, 0);
    check("rst_cap", bus0.captured, 0);
    check("rst_busy1", bus1.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AND gate, matching table
    start_run(0, 0, 1'b0);
    wait_done("and", 0, 1, 8);

    // XOR gate against AND table
    start_run(0, 1, 1'b0);
    wait_done("xor", 0, 1, 8);

    // NAND: every vector mismatches, err_count reaches its maximum
    start_run(0, 3, 1'b0);
    wait_done("nand", 0, 1, 8);

    // OR gate
    start_run(0, 2, 1'b0);
    wait_done("or", 0, 1, 8);

    // Longer settle time
    start_run(1, 0, 1'b0);
    wait_done("s3", 0, 3, 16);
    sel = 0;

    // start during SETTLE of vector 1 is ignored
    start_run(0, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("sc4_vec1", m_vec, 1);
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    wait_done("sc4", 3, 1, 8);
    expect_no_done("sc4_no_second_done", 12);

    // abort in SAMPLE of vector 2
    start_run(0, 0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("abort_pre_vec", m_vec, 2);
    check("abort_pre_busy", m_busy, 1);
    bus0.abort = 1'b1;
    @(posedge clk); #1;
    bus0.abort = 1'b0;
    check("abort_busy", m_busy, 0);
    check("abort_vec", m_vec, 0);
    check("abort_rv", m_rv, 0);
    check("abort_done", m_done, 0);
    void'(q.pop_front());
    expect_no_done("abort_no_done", 12);
    start_run(0, 0, 1'b0);
    wait_done("post_abort", 0, 1, 8);

    // abort in IDLE ignored; start wins when both high
    start_run(0, 1, 1'b1);
    wait_done("start_abort", 0, 1, 8);

    // asynchronous reset mid-run
    start_run(0, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("mrst_vec", bus0.vec_out, 0);
    check("mrst_busy", bus0.busy, 0);
    check("mrst_rv", bus0.result_valid, 0);
    check("mrst_err", bus0.err_count, 0);
    check("mrst_cap", bus0.captured, 0);
    void'(q.pop_front());
    @(posedge clk); #1;
    check("mrst_done", bus0.done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_run(0, 0, 1'b0);
    wait_done("post_reset", 0, 1, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
